// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller: hazard stalls, branch flushes and data-memory
// wait handling, with a sticky memory-timeout error and saturating perf counters.
module hazard_stall_ctrl #(
   parameter int MEM_TIMEOUT = 255,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       src1_ID,
   input  logic [4:0]       src2_ID,
   input  logic             two_src_ID,
   input  logic [4:0]       dest_EXE,
   input  logic             WB_EN_EXE,
   input  logic             MEM_R_EN_EXE,
   input  logic [4:0]       dest_MEM,
   input  logic             WB_EN_MEM,
   input  logic             forward_EN,
   input  logic             br_taken_EXE,
   input  logic             mem_req_MEM,
   input  logic             mem_ready,
   output logic             freeze_PC,
   output logic             freeze_IF_ID,
   output logic             bubble_ID_EXE,
   output logic             flush_IF_ID,
   output logic             freeze_back,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam logic [1:0]  ST_RUN      = 2'd0;
   localparam logic [1:0]  ST_MEM_WAIT = 2'd1;
   localparam logic [1:0]  ST_ERR      = 2'd2;
   localparam logic [15:0] TIMEOUT_C   = 16'(MEM_TIMEOUT);

   logic [1:0]       state_r;
   logic [1:0]       state_nxt_s;
   logic [15:0]      wait_cnt_r;
   logic             mem_err_r;
   logic [CNT_W-1:0] stall_cnt_r;
   logic [CNT_W-1:0] flush_cnt_r;
   logic             src1_used_s;
   logic             src2_used_s;
   logic             match_exe_s;
   logic             match_mem_s;
   logic             hz_s;
   logic             mem_stall_s;
   logic             err_set_s;

   // Register-dependency hazard detection against EXE and MEM destinations
   always_comb begin
      src1_used_s = (src1_ID != 5'd0);
      src2_used_s = two_src_ID && (src2_ID != 5'd0);
      match_exe_s = (src1_used_s && (src1_ID == dest_EXE)) ||
                    (src2_used_s && (src2_ID == dest_EXE));
      match_mem_s = (src1_used_s && (src1_ID == dest_MEM)) ||
                    (src2_used_s && (src2_ID == dest_MEM));
      if (forward_EN) begin
         hz_s = MEM_R_EN_EXE && WB_EN_EXE && match_exe_s;
      end else begin
         hz_s = (WB_EN_EXE && match_exe_s) || (WB_EN_MEM && match_mem_s);
      end
   end

   // Memory-handshake state machine: next state, stall request and timeout
   always_comb begin
      state_nxt_s = state_r;
      mem_stall_s = 1'b0;
      err_set_s   = 1'b0;
      case (state_r)
         ST_RUN: begin
            mem_stall_s = mem_req_MEM && !mem_ready;
            if (mem_req_MEM && !mem_ready) begin
               state_nxt_s = ST_MEM_WAIT;
            end else begin
               state_nxt_s = ST_RUN;
            end
         end
         ST_MEM_WAIT: begin
            mem_stall_s = !mem_ready;
            // wait_cnt_r holds completed wait cycles; +1 counts the current one
            if (mem_ready) begin
               state_nxt_s = ST_RUN;
            end else if ((wait_cnt_r + 16'd1) == TIMEOUT_C) begin
               state_nxt_s = ST_ERR;
               err_set_s   = 1'b1;
            end else begin
               state_nxt_s = ST_MEM_WAIT;
            end
         end
         ST_ERR: begin
            mem_stall_s = 1'b1;
            state_nxt_s = ST_ERR;
         end
         default: begin
            mem_stall_s = 1'b1;
            state_nxt_s = ST_ERR;
            err_set_s   = 1'b1;
         end
      endcase
   end

   // Prioritised pipeline control: memory stall, then branch, then hazard
   always_comb begin
      freeze_PC     = 1'b0;
      freeze_IF_ID  = 1'b0;
      bubble_ID_EXE = 1'b0;
      flush_IF_ID   = 1'b0;
      freeze_back   = 1'b0;
      if (mem_stall_s) begin
         freeze_PC    = 1'b1;
         freeze_IF_ID = 1'b1;
         freeze_back  = 1'b1;
      end else if (br_taken_EXE) begin
         flush_IF_ID   = 1'b1;
         bubble_ID_EXE = 1'b1;
      end else if (hz_s) begin
         freeze_PC     = 1'b1;
         freeze_IF_ID  = 1'b1;
         bubble_ID_EXE = 1'b1;
      end else begin
         freeze_PC     = 1'b0;
      end
   end

   // State, wait counter, sticky error and saturating performance counters
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_RUN;
         wait_cnt_r  <= 16'd0;
         mem_err_r   <= 1'b0;
         stall_cnt_r <= {CNT_W{1'b0}};
         flush_cnt_r <= {CNT_W{1'b0}};
      end else begin
         state_r <= state_nxt_s;
         if (state_r == ST_MEM_WAIT) begin
            wait_cnt_r <= wait_cnt_r + 16'd1;
         end else begin
            wait_cnt_r <= 16'd0;
         end
         if (err_set_s) begin
            mem_err_r <= 1'b1;
         end
         if (freeze_PC && (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + CNT_W'(1'b1);
         end
         if (flush_IF_ID && (flush_cnt_r != {CNT_W{1'b1}})) begin
            flush_cnt_r <= flush_cnt_r + CNT_W'(1'b1);
         end
      end
   end

   assign mem_err   = mem_err_r;
   assign stall_cnt = stall_cnt_r;
   assign flush_cnt = flush_cnt_r;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: the driver queues hand-computed
// expectations per cycle, a monitor on the falling edge pops and compares.
module tb_hazard_stall_ctrl;

   localparam logic [5:0] NONE  = 6'b000000;
   localparam logic [5:0] HZ    = 6'b111000;
   localparam logic [5:0] BR    = 6'b001100;
   localparam logic [5:0] MEMST = 6'b110010;
   localparam logic [5:0] ERRST = 6'b110011;

   typedef struct {
      string      name;
      logic [5:0] ctrl;
      logic       chk_cnt;
      logic [3:0] sc;
      logic [3:0] fc;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] src1_ID, src2_ID, dest_EXE, dest_MEM;
   logic       two_src_ID, WB_EN_EXE, MEM_R_EN_EXE, WB_EN_MEM, forward_EN;
   logic       br_taken_EXE, mem_req_MEM, mem_ready;
   logic       freeze_PC, freeze_IF_ID, bubble_ID_EXE, flush_IF_ID, freeze_back, mem_err;
   logic [3:0] stall_cnt, flush_cnt;

   exp_t exp_q[$];
   exp_t mon_e;
   logic [5:0] mon_act;
   int checks   = 0;
   int failures = 0;

   hazard_stall_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
      .clk(clk), .rst(rst),
      .src1_ID(src1_ID), .src2_ID(src2_ID), .two_src_ID(two_src_ID),
      .dest_EXE(dest_EXE), .WB_EN_EXE(WB_EN_EXE), .MEM_R_EN_EXE(MEM_R_EN_EXE),
      .dest_MEM(dest_MEM), .WB_EN_MEM(WB_EN_MEM), .forward_EN(forward_EN),
      .br_taken_EXE(br_taken_EXE), .mem_req_MEM(mem_req_MEM), .mem_ready(mem_ready),
      .freeze_PC(freeze_PC), .freeze_IF_ID(freeze_IF_ID), .bubble_ID_EXE(bubble_ID_EXE),
      .flush_IF_ID(flush_IF_ID), .freeze_back(freeze_back), .mem_err(mem_err),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   task automatic clr_in();
      rst = 1'b0; src1_ID = 5'd0; src2_ID = 5'd0; two_src_ID = 1'b0;
      dest_EXE = 5'd0; WB_EN_EXE = 1'b0; MEM_R_EN_EXE = 1'b0;
      dest_MEM = 5'd0; WB_EN_MEM = 1'b0; forward_EN = 1'b1;
      br_taken_EXE = 1'b0; mem_req_MEM = 1'b0; mem_ready = 1'b0;
   endtask

   task automatic load_use(input logic [4:0] r);
      forward_EN = 1'b1; MEM_R_EN_EXE = 1'b1; WB_EN_EXE = 1'b1;
      dest_EXE = r; src1_ID = r;
   endtask

   task automatic step(input string name, input logic [5:0] ctrl,
                       input logic chk, input logic [3:0] sc, input logic [3:0] fc);
      exp_t e;
      e.name = name; e.ctrl = ctrl; e.chk_cnt = chk; e.sc = sc; e.fc = fc;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   // Monitor: one comparison set per cycle, taken on the falling edge
   initial begin
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            mon_e   = exp_q.pop_front();
            mon_act = {freeze_PC, freeze_IF_ID, bubble_ID_EXE, flush_IF_ID, freeze_back, mem_err};
            checks++;
            if (mon_act !== mon_e.ctrl) begin
               failures++;
               $display("FAIL %s ctrl(fPC,fIF,bub,flush,fback,err) actual=%b required=%b",
                        mon_e.name, mon_act, mon_e.ctrl);
            end
            if (mon_e.chk_cnt) begin
               checks++;
               if ({stall_cnt, flush_cnt} !== {mon_e.sc, mon_e.fc}) begin
                  failures++;
                  $display("FAIL %s counters actual stall=%0d flush=%0d required stall=%0d flush=%0d",
                           mon_e.name, stall_cnt, flush_cnt, mon_e.sc, mon_e.fc);
               end
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog time limit expired");
      $fatal(1);
   end

   initial begin
      clr_in();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      clr_in();
      step("reset_state", NONE, 1'b1, 4'd0, 4'd0);

      // Load-use with forwarding
      load_use(5'd5);                 step("load_use", HZ, 1'b1, 4'd0, 4'd0);
      clr_in();                       step("load_use_after", NONE, 1'b1, 4'd1, 4'd0);
      load_use(5'd0);                 step("dest_zero", NONE, 1'b0, 4'd0, 4'd0);
      load_use(5'd5); WB_EN_EXE = 1'b0; step("load_no_wb", NONE, 1'b0, 4'd0, 4'd0);
      load_use(5'd5); src1_ID = 5'd0; src2_ID = 5'd5; two_src_ID = 1'b0;
      step("src2_unused", NONE, 1'b0, 4'd0, 4'd0);
      two_src_ID = 1'b1;              step("src2_load_use", HZ, 1'b0, 4'd0, 4'd0);
      clr_in(); WB_EN_EXE = 1'b1; dest_EXE = 5'd5; src1_ID = 5'd5;
      step("fwd_alu_raw", NONE, 1'b1, 4'd2, 4'd0);

      // RAW without forwarding
      clr_in(); forward_EN = 1'b0; WB_EN_MEM = 1'b1; dest_MEM = 5'd7; src2_ID = 5'd7; two_src_ID = 1'b1;
      step("nofwd_mem_raw", HZ, 1'b0, 4'd0, 4'd0);
      two_src_ID = 1'b0;              step("nofwd_mem_src2_unused", NONE, 1'b0, 4'd0, 4'd0);
      clr_in(); forward_EN = 1'b0; WB_EN_EXE = 1'b1; dest_EXE = 5'd3; src1_ID = 5'd3;
      step("nofwd_exe_raw", HZ, 1'b0, 4'd0, 4'd0);
      src1_ID = 5'd0; dest_EXE = 5'd0; step("nofwd_reg0", NONE, 1'b1, 4'd4, 4'd0);

      // Branch beats hazard
      clr_in(); load_use(5'd9); br_taken_EXE = 1'b1;
      step("branch_vs_hz", BR, 1'b0, 4'd0, 4'd0);
      clr_in();                       step("branch_after", NONE, 1'b1, 4'd4, 4'd1);

      // Memory wait of 3 cycles with a branch held in EXE
      mem_req_MEM = 1'b1; br_taken_EXE = 1'b1;
      step("memwait_c0", MEMST, 1'b0, 4'd0, 4'd0);
      step("memwait_c1", MEMST, 1'b0, 4'd0, 4'd0);
      step("memwait_c2", MEMST, 1'b0, 4'd0, 4'd0);
      mem_ready = 1'b1;               step("memwait_ready_branch", BR, 1'b1, 4'd7, 4'd1);
      clr_in();                       step("memwait_run", NONE, 1'b1, 4'd7, 4'd2);
      mem_req_MEM = 1'b1; mem_ready = 1'b1;
      step("mem_zero_latency", NONE, 1'b1, 4'd7, 4'd2);

      // Timeout into ERR, then reset
      clr_in(); mem_req_MEM = 1'b1;
      step("to_run_req", MEMST, 1'b0, 4'd0, 4'd0);
      for (int i = 0; i < 4; i++) step("to_wait", MEMST, 1'b0, 4'd0, 4'd0);
      clr_in();                       step("err_entered", ERRST, 1'b1, 4'd12, 4'd2);
      load_use(5'd4); br_taken_EXE = 1'b1; mem_ready = 1'b1;
      step("err_stuck", ERRST, 1'b1, 4'd13, 4'd2);
      clr_in(); rst = 1'b1;           step("err_reset_cycle", ERRST, 1'b1, 4'd14, 4'd2);
      clr_in();                       step("post_reset", NONE, 1'b1, 4'd0, 4'd0);

      // Ready on the exact timeout cycle returns to RUN
      mem_req_MEM = 1'b1;             step("edge_run_req", MEMST, 1'b0, 4'd0, 4'd0);
      for (int i = 0; i < 3; i++) step("edge_wait", MEMST, 1'b0, 4'd0, 4'd0);
      mem_ready = 1'b1;               step("edge_ready_at_timeout", NONE, 1'b0, 4'd0, 4'd0);
      clr_in();                       step("edge_no_err", NONE, 1'b1, 4'd4, 4'd0);
      mem_req_MEM = 1'b1; mem_ready = 1'b1;
      step("edge_in_run", NONE, 1'b0, 4'd0, 4'd0);

      // Counter saturation
      clr_in(); rst = 1'b1;           step("sat_reset", NONE, 1'b1, 4'd4, 4'd0);
      clr_in(); load_use(5'd12);
      for (int i = 0; i < 20; i++) begin
         step("sat_stall", HZ, 1'b1, (i < 15) ? 4'(i) : 4'd15, 4'd0);
      end
      clr_in(); br_taken_EXE = 1'b1;  step("sat_branch", BR, 1'b1, 4'd15, 4'd0);
      clr_in();                       step("sat_final", NONE, 1'b1, 4'd15, 4'd1);

      repeat (3) @(posedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain actual=%0d pending required=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
